fun_fpsu_array: RTL

FUN_FPSU_ARRAY -- requirements
Module: fun_fpsu_array

---
 rtl/fun_fpsu_array.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/fun_fpsu_array.sv
// FP store-data lanes: a 2-stage operand-select pipeline per lane, with a shared
// alt-data FIFO fed from stage 1 through round-robin arbitration and pending slots.
module fun_fpsu_array #(
  parameter int CHANNELS = 3,
  parameter int WIDTH    = 68,
  parameter int NFWD     = 10,
  parameter int DEPTH    = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] u_A,
  input  logic [CHANNELS-1:0]       u_en,
  input  logic [CHANNELS*13-1:0]    u_op,
  input  logic [CHANNELS*4-1:0]     u_fwd,
  input  logic [CHANNELS-1:0]       u_XSUB,
  input  logic [NFWD*WIDTH-1:0]     FUF,
  output logic [CHANNELS*WIDTH-1:0] xdata2,
  output logic [CHANNELS*14-1:0]    u_ret,
  output logic [CHANNELS-1:0]       u_ret_en,
  output logic [CHANNELS*6-1:0]     FOOSL_out,
  output logic [WIDTH-1:0]          XI_data,
  output logic                      XI_valid,
  input  logic                      XI_ready
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int LW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  function automatic logic [WIDTH-1:0] fwd_sel(input logic [3:0] idx,
                                               input logic [WIDTH-1:0] a,
                                               input logic [NFWD*WIDTH-1:0] bus);
    logic [WIDTH-1:0] r;
    r = a;
    for (int k = 0; k < NFWD; k++)
      if (idx == 4'(k)) r = bus[k*WIDTH +: WIDTH];
    return r;
  endfunction

  // Returns {found, index}; scanning downward lets the smallest offset win.
  function automatic logic [LW:0] rr_pick(input logic [CHANNELS-1:0] c,
                                          input logic [LW-1:0] start);
    logic [LW:0] r;
    r = '0;
    for (int off = CHANNELS - 1; off >= 0; off--)
      if (c[(int'(start) + off) % CHANNELS])
        r = {1'b1, LW'((int'(start) + off) % CHANNELS)};
    return r;
  endfunction

  logic [WIDTH-1:0]    sel_p0   [CHANNELS];
  logic [CHANNELS-1:0] vld_p1, xsub_p1;
  logic [WIDTH-1:0]    data_p1  [CHANNELS];
  logic [12:0]         op_p1    [CHANNELS];
  logic [5:0]          foosl_p1 [CHANNELS];
  logic [CHANNELS-1:0] vld_p2;
  logic [WIDTH-1:0]    xdata_p2 [CHANNELS];
  logic [13:0]         ret_p2   [CHANNELS];

  logic [CHANNELS-1:0] pend_vld;
  logic [WIDTH-1:0]    pend_data [CHANNELS];
  logic [LW-1:0]       rr_ptr;

  logic [CHANNELS-1:0] req, cand, gnt_oh, drop, to_pend, pend_clr;
  logic [LW:0]         pick;
  logic [LW-1:0]       gnt_idx;
  logic                use_pend, gnt_any, can_push, push, pop;
  logic [WIDTH-1:0]    push_data;

  logic [WIDTH-1:0]    mem [DEPTH];
  logic [AW-1:0]       wr_ptr, rd_ptr;
  logic [CW-1:0]       occ;

  // Stage 0: operand select
  always_comb begin
    for (int i = 0; i < CHANNELS; i++)
      sel_p0[i] = fwd_sel(u_fwd[i*4 +: 4], u_A[i*WIDTH +: WIDTH], FUF);
  end

  // Stage 1: issue registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p1 <= '0;
      for (int i = 0; i < CHANNELS; i++) foosl_p1[i] <= '0;
    end else begin
      vld_p1 <= u_en;
      for (int i = 0; i < CHANNELS; i++)
        foosl_p1[i] <= u_en[i] ? {1'b1, u_XSUB[i], u_op[i*13 +: 4]} : 6'd0;
    end
  end

  always_ff @(posedge clk) begin
    xsub_p1 <= u_XSUB;
    for (int i = 0; i < CHANNELS; i++) begin
      data_p1[i] <= sel_p0[i];
      op_p1[i]   <= u_op[i*13 +: 13];
    end
  end

  // Alt-FIFO arbitration: pending entries outrank new requests.
  always_comb begin
    pop       = XI_valid && XI_ready;
    req       = vld_p1 & xsub_p1;
    use_pend  = |pend_vld;
    cand      = use_pend ? pend_vld : req;
    pick      = rr_pick(cand, rr_ptr);
    gnt_any   = pick[LW];
    gnt_idx   = pick[LW-1:0];
    can_push  = (occ != CW'(DEPTH)) || pop;
    push      = gnt_any && can_push;
    push_data = use_pend ? pend_data[gnt_idx] : data_p1[gnt_idx];
    for (int i = 0; i < CHANNELS; i++) begin
      gnt_oh[i]   = gnt_any && (gnt_idx == LW'(i));
      drop[i]     = req[i] && (pend_vld[i] || (!use_pend && gnt_oh[i] && !can_push));
      to_pend[i]  = req[i] && !pend_vld[i] && !(!use_pend && gnt_oh[i]);
      pend_clr[i] = use_pend && gnt_oh[i] && push;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_vld <= '0;
      rr_ptr   <= '0;
    end else begin
      pend_vld <= (pend_vld & ~pend_clr) | to_pend;
      if (gnt_any)
        rr_ptr <= (gnt_idx == LW'(CHANNELS - 1)) ? '0 : gnt_idx + LW'(1);
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < CHANNELS; i++)
      if (to_pend[i]) pend_data[i] <= data_p1[i];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      occ <= occ + CW'(1);
      else if (pop && !push) occ <= occ - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign XI_valid = (occ != '0);
  assign XI_data  = XI_valid ? mem[rd_ptr] : '0;

  // Stage 2: retire registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p2 <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        xdata_p2[i] <= '0;
        ret_p2[i]   <= '0;
      end
    end else begin
      vld_p2 <= vld_p1;
      for (int i = 0; i < CHANNELS; i++)
        if (vld_p1[i]) begin
          xdata_p2[i] <= data_p1[i];
          ret_p2[i]   <= {drop[i], op_p1[i]};
        end
    end
  end

  assign u_ret_en = vld_p2;
  for (genvar g = 0; g < CHANNELS; g++) begin : g_out
    assign xdata2[g*WIDTH +: WIDTH] = xdata_p2[g];
    assign u_ret[g*14 +: 14]        = ret_p2[g];
    assign FOOSL_out[g*6 +: 6]      = foosl_p1[g];
  end

endmodule
